// File: rtl/fdiv_arb.sv
// Round-robin arbiter sharing one combinational fdiv core among NREQ requesters,
// with a registered issue stage, LAT re-timing stages and a credit-protected response FIFO.
// Optional build macro FDIV_SPECIAL_EN: +/-0 divisor yields signed infinity and rsp_dz=1.
module fdiv_arb #(
  parameter int N     = 32,
  parameter int NREQ  = 4,
  parameter int LAT   = 2,
  parameter int DEPTH = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic [N-1:0]      div_a,
  output logic [N-1:0]      div_b,
  input  logic [N-1:0]      div_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [N-1:0]      rsp_data,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_dz
);

  localparam int OW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [OW-1:0]   occ;
  logic [IDW-1:0]  ptr;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gidx;
  logic            found;
  int unsigned     idx;
  logic            hs;
  logic            pop;
  logic [N-1:0]    a_sel;
  logic [N-1:0]    b_sel;

  // Grant search starts just past the last winner so each requester gets a turn.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    if (!rst && (occ < OW'(DEPTH))) begin
      for (int unsigned k = 1; k <= NREQ; k++) begin
        idx = (int'(ptr) + k) % NREQ;
        if (!found && req_valid[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          gidx       = IDW'(idx);
        end
      end
    end
  end

  assign req_ready = grant;
  assign hs        = found;
  assign a_sel     = req_a[gidx*N +: N];
  assign b_sel     = req_b[gidx*N +: N];

  // Issue register feeding the core
  logic [N-1:0]   ia, ib;
  logic [IDW-1:0] iid;
  logic           ivld;

  always_ff @(posedge clk) begin
    if (rst) begin
      ia   <= '0;
      ib   <= '0;
      iid  <= '0;
      ivld <= 1'b0;
    end else if (hs) begin
      ia   <= a_sel;
      ib   <= b_sel;
      iid  <= gidx;
      ivld <= 1'b1;
    end else begin
      ivld <= 1'b0;
    end
  end

  assign div_a = ia;
  assign div_b = ib;

  // Stage-1 data: core result, or signed infinity when the divisor is zero
  logic [N-1:0] s1_data;
`ifdef FDIV_SPECIAL_EN
  localparam int EW = (N == 64) ? 11 : 8;
  logic idz;
  assign s1_data = idz ? {ia[N-1] ^ ib[N-1], {EW{1'b1}}, {(N-1-EW){1'b0}}} : div_out;
`else
  assign s1_data = div_out;
`endif

  logic [N-1:0]   sd   [LAT];
  logic [IDW-1:0] sid  [LAT];
  logic           svld [LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < LAT; k++) begin
        sd[k]   <= '0;
        sid[k]  <= '0;
        svld[k] <= 1'b0;
      end
    end else begin
      sd[0]   <= s1_data;
      sid[0]  <= iid;
      svld[0] <= ivld;
      for (int unsigned k = 1; k < LAT; k++) begin
        sd[k]   <= sd[k-1];
        sid[k]  <= sid[k-1];
        svld[k] <= svld[k-1];
      end
    end
  end

  // Response FIFO
  logic [N-1:0]   mem_d  [DEPTH];
  logic [IDW-1:0] mem_id [DEPTH];
  logic [PW-1:0]  wptr, rptr;
  logic [OW-1:0]  fcnt;
  logic           wr;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign wr        = svld[LAT-1];
  assign rsp_valid = !rst && (fcnt != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_data  = mem_d[rptr];
  assign rsp_id    = mem_id[rptr];

  always_ff @(posedge clk) begin
    if (wr) begin
      mem_d[wptr]  <= sd[LAT-1];
      mem_id[wptr] <= sid[LAT-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      fcnt <= '0;
      occ  <= '0;
      ptr  <= IDW'(NREQ - 1);
    end else begin
      if (wr)  wptr <= nxt(wptr);
      if (pop) rptr <= nxt(rptr);
      case ({wr, pop})
        2'b10:   fcnt <= fcnt + 1'b1;
        2'b01:   fcnt <= fcnt - 1'b1;
        default: fcnt <= fcnt;
      endcase
      // Credits cover both the pipeline and the FIFO, so the FIFO cannot overflow.
      case ({hs, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      if (hs) ptr <= gidx;
    end
  end

`ifdef FDIV_SPECIAL_EN
  logic sdz    [LAT];
  logic mem_dz [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      idz <= 1'b0;
      for (int unsigned k = 0; k < LAT; k++) sdz[k] <= 1'b0;
    end else begin
      if (hs) idz <= (b_sel[N-2:0] == '0);
      sdz[0] <= idz;
      for (int unsigned k = 1; k < LAT; k++) sdz[k] <= sdz[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_dz[wptr] <= sdz[LAT-1];
  end

  assign rsp_dz = mem_dz[rptr];
`else
  assign rsp_dz = 1'b0;
`endif

endmodule

// File: tb/tb_fdiv_arb.sv
// Scoreboard bench for fdiv_arb: random and directed traffic, a stand-in fdiv core,
// and a transaction-level model of credits, round-robin order and response timing.
module tb_fdiv_arb;
  localparam int N     = 32;
  localparam int NREQ  = 4;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int IDW   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a, req_b;
  logic [N-1:0]      div_a, div_b, div_out;
  logic              rsp_valid, rsp_ready;
  logic [N-1:0]      rsp_data;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_dz;

  fdiv_arb #(.N(N), .NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH), .IDW(IDW)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .div_a(div_a), .div_b(div_b), .div_out(div_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_dz(rsp_dz)
  );

  always #5 clk = ~clk;

  // Stand-in core: exact for the directed 6.0/2.0 case, a data-dependent scramble otherwise.
  function automatic logic [31:0] core(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
    return (a ^ {b[7:0], b[31:8]}) + 32'h01234567;
  endfunction

  assign div_out = core(div_a, div_b);

  function automatic logic exp_dz(input logic [31:0] b);
`ifdef FDIV_SPECIAL_EN
    return (b & 32'h7FFFFFFF) == 32'h0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_data(input logic [31:0] a, input logic [31:0] b);
    if (exp_dz(b)) return {a[31] ^ b[31], 8'hFF, 23'h0};
    return core(a, b);
  endfunction

  typedef struct {
    logic [31:0] d;
    logic [1:0]  id;
    logic        dz;
    int unsigned rdy;
  } rsp_t;

  rsp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  int          occ_m = 0;
  int          ptr_m = NREQ - 1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, expv);
    end
  endtask

  // Monitor: samples 2 time units after the falling edge, when inputs are settled.
  always @(negedge clk) begin
    logic [NREQ-1:0] exp_g;
    int              g;
    bit              exp_v;
    #2;
    if (rst) begin
      check(req_ready == '0, "rst_ready", 64'(req_ready), 64'h0);
      check(rsp_valid == 1'b0, "rst_valid", 64'(rsp_valid), 64'h0);
      sb.delete();
      occ_m = 0;
      ptr_m = NREQ - 1;
    end else begin
      exp_g = '0;
      g     = -1;
      if (occ_m < DEPTH) begin
        for (int k = 1; k <= NREQ; k++) begin
          if (g < 0 && req_valid[(ptr_m + k) % NREQ]) g = (ptr_m + k) % NREQ;
        end
      end
      if (g >= 0) exp_g[g] = 1'b1;
      check(req_ready == exp_g, "grant", 64'(req_ready), 64'(exp_g));

      exp_v = (sb.size() > 0) && (sb[0].rdy <= cyc);
      check(rsp_valid == exp_v, "rsp_valid", 64'(rsp_valid), 64'(exp_v));
      if (rsp_valid && exp_v) begin
        check(rsp_data == sb[0].d, "rsp_data", 64'(rsp_data), 64'(sb[0].d));
        check(rsp_id == sb[0].id, "rsp_id", 64'(rsp_id), 64'(sb[0].id));
        check(rsp_dz == sb[0].dz, "rsp_dz", 64'(rsp_dz), 64'(sb[0].dz));
      end

      if (g >= 0) begin
        sb.push_back('{d: exp_data(req_a[g*N +: N], req_b[g*N +: N]), id: 2'(g),
                       dz: exp_dz(req_b[g*N +: N]), rdy: cyc + 2 + LAT});
        ptr_m = g;
        occ_m++;
      end
      if (exp_v && rsp_ready) begin
        void'(sb.pop_front());
        occ_m--;
      end
    end
  end

  task automatic drive(input logic [NREQ-1:0] v, input bit rr);
    @(negedge clk);
    req_valid = v;
    rsp_ready = rr;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*N +: N] = $urandom;
      case ($urandom_range(0, 7))
        0:       req_b[i*N +: N] = 32'h0;
        1:       req_b[i*N +: N] = 32'h80000000;
        default: req_b[i*N +: N] = $urandom;
      endcase
    end
  endtask

  task automatic drive_one(input int i, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    req_valid = '0;
    req_valid[i] = 1'b1;
    rsp_ready = 1'b1;
    req_a[i*N +: N] = a;
    req_b[i*N +: N] = b;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_a = '0;
    req_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    drive_one(1, 32'h40C00000, 32'h40000000);
    repeat (8) drive('0, 1'b1);

    repeat (8) drive('1, 1'b1);
    repeat (8) drive('0, 1'b1);

    repeat (10) drive('1, 1'b0);
    repeat (10) drive('1, 1'b1);
    repeat (8) drive('0, 1'b1);

    for (int n = 0; n < 3000; n++) drive(NREQ'($urandom), ($urandom_range(0, 3) != 0));
    for (int n = 0; n < 500; n++) drive(NREQ'($urandom), ($urandom_range(0, 3) == 0));
    repeat (10) drive('0, 1'b1);

    repeat (3) drive('1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) drive('1, 1'b1);
    repeat (10) drive('0, 1'b1);

    drive_one(0, 32'h3F800000, 32'h00000000);
    drive_one(1, 32'hBF800000, 32'h80000000);
    drive_one(2, 32'hBF800000, 32'h00000000);
    drive_one(3, 32'h40C00000, 32'h40000000);
    repeat (20) drive('0, 1'b1);

    @(negedge clk);
    #3;
    check(sb.size() == 0, "drain", 64'(sb.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
